addr_mux_arbiter: RTL and testbench
===================================

ADDR_MUX_ARBITER -- requirements
Module: addr_mux_arbiter

Interface
REQ-001 Parameter AddrWidth, default 24, width of requester and memory address buses.
REQ-002 Parameter FixedPriority, default 0; 0 = round-robin, 1 = requester A always wins ties.
REQ-003 Parameter TimeoutCycles, default 255, max GRANT cycles awaiting mem_ack; legal range 1..255.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 a_req  input  1  requester A (data port) transfer request, level.
REQ-007 a_addr  input  AddrWidth  requester A address, stable while a_req high.
REQ-008 a_gnt  output  1  A owns the memory address path.
REQ-009 a_done  output  1  one-cycle pulse, A transfer complete or aborted.
REQ-010 b_req  input  1  requester B (fetch port) transfer request, level.
REQ-011 b_addr  input  AddrWidth  requester B address, stable while b_req high.
REQ-012 b_gnt  output  1  B owns the memory address path.
REQ-013 b_done  output  1  one-cycle pulse, B transfer complete or aborted.
REQ-014 mem_ack  input  1  memory completes current transfer (one-cycle pulse).
REQ-015 mem_valid  output  1  mem_addr is valid, transfer in progress.
REQ-016 mem_addr  output  AddrWidth  selected address: a_addr when a_select=1, else b_addr.
REQ-017 a_select  output  1  registered mux select, 1 = A path.
REQ-018 timeout_err  output  1  one-cycle pulse when a transfer is aborted on timeout.

Function
REQ-019 FSM SHALL have states IDLE, GRANT, RELEASE.
REQ-020 IDLE: if any req high, next cycle enter GRANT with owner chosen; else stay IDLE.
REQ-021 Arbitration: single request wins; both requesting -> FixedPriority=1 grants A, else grant the requester not equal to last_owner.
REQ-022 Entering GRANT: a_select, x_gnt, mem_valid all go high in the same cycle (registered, 1-cycle grant latency from req).
REQ-023 GRANT: hold owner, a_select, mem_valid; count cycles; a req dropping during GRANT does not end GRANT.
REQ-024 mem_ack high in GRANT -> next cycle RELEASE, x_done=1 for owner, x_gnt=0, mem_valid=0, last_owner updated.
REQ-025 Timeout counter reaching TimeoutCycles without mem_ack -> RELEASE with x_done=1 and timeout_err=1 same cycle.
REQ-026 mem_ack and timeout in same cycle: ack wins, timeout_err stays 0.
REQ-027 RELEASE lasts exactly one cycle, then IDLE; requester must drop req in its done cycle or it is treated as a new request.
REQ-028 mem_ack outside GRANT SHALL be ignored.
REQ-029 a_select holds its last value in IDLE and RELEASE (no address glitch on idle bus).
REQ-030 a_gnt and b_gnt SHALL never be high simultaneously; done pulses never overlap.
REQ-031 mem_addr SHALL be purely combinational from a_select and addresses (zero added latency).

Reset
REQ-032 reset_n low: state=IDLE, a_gnt=b_gnt=0, a_done=b_done=0, mem_valid=0, a_select=0, timeout_err=0, counter=0, last_owner=B, immediately and asynchronously.
REQ-033 Reset asserted mid-GRANT aborts transfer with no done pulse.
REQ-034 First cycle after reset release SHALL be IDLE evaluation.

Structure
REQ-035 Shared package holds FSM state encoding (2-bit) and owner encoding constants (OWNER_A=1, OWNER_B=0).
REQ-036 Address path SHALL instantiate MUX12 (A_in=a_addr, B_in=b_addr, A_Select=a_select, AddrWidth passed through); no other sub-modules.
REQ-037 Timeout counter 8 bits, saturating, cleared on entering GRANT.

Verification
REQ-038 Only a_req=1 at cycle 0 -> cycle 1 a_gnt=1, a_select=1, mem_valid=1, mem_addr=a_addr; mem_ack at cycle 3 -> cycle 4 a_done=1, mem_valid=0.
REQ-039 a_req and b_req both high after reset, FixedPriority=0 -> A granted first, then B after RELEASE/IDLE, then A again (alternation over 4 transfers).
REQ-040 FixedPriority=1, both held high across 3 transfers -> A granted all 3, B never.
REQ-041 TimeoutCycles=4, grant B, no mem_ack -> after 4 GRANT cycles b_done=1 and timeout_err=1 together; mem_ack on the limit cycle -> timeout_err=0.
REQ-042 reset_n low during GRANT -> all outputs at reset values same cycle, no done pulse; stray mem_ack in IDLE -> no output change.

Source files
------------

// File: rtl/addr_mux_arbiter_pkg.sv
// Shared types for the two-requester memory address arbiter.
// Holds the FSM state encoding, the owner encoding and the arbitration helper.
package addr_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic OWNER_A   = 1'b1;
    localparam logic OWNER_B   = 1'b0;
    localparam int   CntWidth  = 8;

    // A lone requester always wins; a tie goes to A under fixed priority, otherwise to whoever did not own the bus last.
    function automatic logic pick_owner(input logic a_req, input logic b_req,
                                        input logic fixed_prio, input logic last_owner);
        logic owner;
        if (a_req && !b_req) begin
            owner = OWNER_A;
        end else if (b_req && !a_req) begin
            owner = OWNER_B;
        end else if (fixed_prio) begin
            owner = OWNER_A;
        end else begin
            owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
        end
        return owner;
    endfunction

endpackage

// File: rtl/addr_mux_arbiter_mux12.sv
// Two-to-one address multiplexer feeding the memory address bus.
// Latency: combinational. Backpressure: none, pure datapath.
// The select comes from a register upstream, so the output only moves when ownership changes.
module MUX12 #(
    parameter int AddrWidth = 24
) (
    input  logic [AddrWidth-1:0] A_in,
    input  logic [AddrWidth-1:0] B_in,
    input  logic                 A_Select,
    output logic [AddrWidth-1:0] mux_out
);

    assign mux_out = A_Select ? A_in : B_in;

endmodule

// File: rtl/addr_mux_arbiter.sv
// Arbitrates data port A and fetch port B onto one memory address path, with an ack timeout.
// Latency: grant one cycle after req; done/timeout one cycle after mem_ack or the last timeout cycle.
// Backpressure: requesters hold req until done; memory stalls by withholding mem_ack up to TimeoutCycles.
module addr_mux_arbiter
    import addr_mux_arbiter_pkg::*;
#(
    parameter int AddrWidth     = 24,
    parameter bit FixedPriority = 1'b0,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [AddrWidth-1:0] a_addr,
    output logic                 a_gnt,
    output logic                 a_done,
    input  logic                 b_req,
    input  logic [AddrWidth-1:0] b_addr,
    output logic                 b_gnt,
    output logic                 b_done,
    input  logic                 mem_ack,
    output logic                 mem_valid,
    output logic [AddrWidth-1:0] mem_addr,
    output logic                 a_select,
    output logic                 timeout_err
);

    // The counter starts at zero in the first GRANT cycle, so the last permitted cycle sees TimeoutCycles-1.
    localparam logic [CntWidth-1:0] TimeoutLimit = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntMax       = {CntWidth{1'b1}};

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                a_gnt_d, b_gnt_d, a_done_d, b_done_d;
    logic                mem_valid_d, a_select_d, timeout_err_d;
    logic                winner;

    assign winner = pick_owner(a_req, b_req, FixedPriority, last_owner_q);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        cnt_d         = cnt_q;
        a_gnt_d       = a_gnt;
        b_gnt_d       = b_gnt;
        mem_valid_d   = mem_valid;
        a_select_d    = a_select;
        a_done_d      = 1'b0;
        b_done_d      = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d     = ST_GRANT;
                    owner_d     = winner;
                    cnt_d       = '0;
                    a_select_d  = (winner == OWNER_A);
                    a_gnt_d     = (winner == OWNER_A);
                    b_gnt_d     = (winner == OWNER_B);
                    mem_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                // An ack on the final permitted cycle still counts as a normal completion.
                if (mem_ack || (cnt_q == TimeoutLimit)) begin
                    state_d       = ST_RELEASE;
                    a_gnt_d       = 1'b0;
                    b_gnt_d       = 1'b0;
                    mem_valid_d   = 1'b0;
                    a_done_d      = (owner_q == OWNER_A);
                    b_done_d      = (owner_q == OWNER_B);
                    last_owner_d  = owner_q;
                    timeout_err_d = !mem_ack;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_B;
            last_owner_q <= OWNER_B;
            cnt_q        <= '0;
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            mem_valid    <= 1'b0;
            a_select     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            a_gnt        <= a_gnt_d;
            b_gnt        <= b_gnt_d;
            a_done       <= a_done_d;
            b_done       <= b_done_d;
            mem_valid    <= mem_valid_d;
            a_select     <= a_select_d;
            timeout_err  <= timeout_err_d;
        end
    end

    MUX12 #(
        .AddrWidth(AddrWidth)
    ) u_addr_mux (
        .A_in    (a_addr),
        .B_in    (b_addr),
        .A_Select(a_select),
        .mux_out (mem_addr)
    );

endmodule

// File: tb/tb_addr_mux_arbiter.sv
// Scoreboard bench: a round-robin instance with a short timeout and a fixed-priority instance.
module tb_addr_mux_arbiter;

    localparam int AW = 24;

    typedef struct {
        logic          owner;
        logic [AW-1:0] addr;
    } gexp_t;

    typedef struct {
        logic owner;
        logic tmo;
    } dexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic          a_req0 = 0, b_req0 = 0, mem_ack0 = 0;
    logic [AW-1:0] a_addr0 = '0, b_addr0 = '0;
    logic          a_gnt0, a_done0, b_gnt0, b_done0, mem_valid0, a_select0, timeout_err0;
    logic [AW-1:0] mem_addr0;

    logic          a_req1 = 0, b_req1 = 0, mem_ack1 = 0;
    logic [AW-1:0] a_addr1 = '0, b_addr1 = '0;
    logic          a_gnt1, a_done1, b_gnt1, b_done1, mem_valid1, a_select1, timeout_err1;
    logic [AW-1:0] mem_addr1;

    int n_checks = 0;
    int n_fail   = 0;

    gexp_t g0_q[$], g1_q[$];
    dexp_t d0_q[$], d1_q[$];
    logic  prev_g0 = 0, prev_g1 = 0;

    always #5 clk = ~clk;

    addr_mux_arbiter #(.AddrWidth(AW), .FixedPriority(1'b0), .TimeoutCycles(4)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req0), .a_addr(a_addr0), .a_gnt(a_gnt0), .a_done(a_done0),
        .b_req(b_req0), .b_addr(b_addr0), .b_gnt(b_gnt0), .b_done(b_done0),
        .mem_ack(mem_ack0), .mem_valid(mem_valid0), .mem_addr(mem_addr0),
        .a_select(a_select0), .timeout_err(timeout_err0)
    );

    addr_mux_arbiter #(.AddrWidth(AW), .FixedPriority(1'b1), .TimeoutCycles(255)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req1), .a_addr(a_addr1), .a_gnt(a_gnt1), .a_done(a_done1),
        .b_req(b_req1), .b_addr(b_addr1), .b_gnt(b_gnt1), .b_done(b_done1),
        .mem_ack(mem_ack1), .mem_valid(mem_valid1), .mem_addr(mem_addr1),
        .a_select(a_select1), .timeout_err(timeout_err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_g0 <= 1'b0;
        end else begin
            gexp_t ge;
            dexp_t de;
            check("d0_gnt_excl", {31'd0, a_gnt0 & b_gnt0}, 32'd0);
            check("d0_valid_vs_gnt", {31'd0, mem_valid0}, {31'd0, a_gnt0 | b_gnt0});
            if ((a_gnt0 || b_gnt0) && !prev_g0) begin
                check("d0_grant_expected", {31'd0, g0_q.size() != 0}, 32'd1);
                if (g0_q.size() != 0) begin
                    ge = g0_q.pop_front();
                    check("d0_gnt_owner", {31'd0, a_gnt0}, {31'd0, ge.owner});
                    check("d0_select", {31'd0, a_select0}, {31'd0, ge.owner});
                    check("d0_mem_addr", {8'd0, mem_addr0}, {8'd0, ge.addr});
                end
            end
            if (a_done0 || b_done0) begin
                check("d0_done_expected", {31'd0, d0_q.size() != 0}, 32'd1);
                if (d0_q.size() != 0) begin
                    de = d0_q.pop_front();
                    check("d0_done_owner", {30'd0, a_done0, b_done0}, {30'd0, de.owner, !de.owner});
                    check("d0_timeout_err", {31'd0, timeout_err0}, {31'd0, de.tmo});
                end
            end else begin
                check("d0_tmo_without_done", {31'd0, timeout_err0}, 32'd0);
            end
            prev_g0 <= a_gnt0 | b_gnt0;
        end
    end

    // Monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_g1 <= 1'b0;
        end else begin
            gexp_t ge;
            dexp_t de;
            check("d1_gnt_excl", {31'd0, a_gnt1 & b_gnt1}, 32'd0);
            if ((a_gnt1 || b_gnt1) && !prev_g1) begin
                check("d1_grant_expected", {31'd0, g1_q.size() != 0}, 32'd1);
                if (g1_q.size() != 0) begin
                    ge = g1_q.pop_front();
                    check("d1_gnt_owner", {30'd0, a_gnt1, b_gnt1}, {30'd0, ge.owner, !ge.owner});
                    check("d1_mem_addr", {8'd0, mem_addr1}, {8'd0, ge.addr});
                end
            end
            if (a_done1 || b_done1) begin
                check("d1_done_expected", {31'd0, d1_q.size() != 0}, 32'd1);
                if (d1_q.size() != 0) begin
                    de = d1_q.pop_front();
                    check("d1_done_owner", {30'd0, a_done1, b_done1}, {30'd0, de.owner, !de.owner});
                    check("d1_timeout_err", {31'd0, timeout_err1}, {31'd0, de.tmo});
                end
            end
            prev_g1 <= a_gnt1 | b_gnt1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // Reset values.
        #2;
        check("rst_outputs", {25'd0, a_gnt0, b_gnt0, a_done0, b_done0, mem_valid0, a_select0, timeout_err0}, 32'd0);
        tick();
        reset_n = 1'b1;

        // Single A transfer, ack on cycle 3.
        a_addr0 = 24'h123456;
        b_addr0 = 24'h0BEEF0;
        a_req0  = 1'b1;
        g0_q.push_back('{owner: 1'b1, addr: 24'h123456});
        d0_q.push_back('{owner: 1'b1, tmo: 1'b0});
        tick();
        check("lat_a_gnt", {29'd0, a_gnt0, a_select0, mem_valid0}, 32'h7);
        check("lat_mem_addr", {8'd0, mem_addr0}, 32'h123456);
        a_req0 = 1'b0;
        tick();
        check("gnt_held_after_req_drop", {31'd0, a_gnt0}, 32'd1);
        tick();
        mem_ack0 = 1'b1;
        tick();
        mem_ack0 = 1'b0;
        check("rel_a_done", {28'd0, a_done0, mem_valid0, a_gnt0, a_select0}, 32'h9);
        tick();
        check("idle_sel_hold", {29'd0, a_select0, a_done0, mem_valid0}, 32'h4);

        // Stray ack in IDLE must not disturb anything.
        mem_ack0 = 1'b1;
        tick();
        mem_ack0 = 1'b0;
        tick();
        check("stray_ack", {25'd0, a_gnt0, b_gnt0, a_done0, b_done0, mem_valid0, a_select0, timeout_err0}, 32'h2);

        // Round-robin alternation with both held high: A, B, A, B.
        do_reset();
        a_addr0 = 24'hA0A0A0;
        b_addr0 = 24'h0B0B0B;
        for (int t = 0; t < 4; t++) begin
            g0_q.push_back('{owner: (t % 2 == 0), addr: (t % 2 == 0) ? 24'hA0A0A0 : 24'h0B0B0B});
            d0_q.push_back('{owner: (t % 2 == 0), tmo: 1'b0});
        end
        a_req0 = 1'b1;
        b_req0 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            while (!(a_gnt0 || b_gnt0) && w < 10) begin
                tick();
                w++;
            end
            check("rr_grant_wait", {31'd0, w < 10}, 32'd1);
            tick();
            mem_ack0 = 1'b1;
            tick();
            mem_ack0 = 1'b0;
            if (t == 3) begin
                a_req0 = 1'b0;
                b_req0 = 1'b0;
            end
        end
        tick();
        tick();

        // Timeout on B after 4 GRANT cycles.
        do_reset();
        b_req0 = 1'b1;
        g0_q.push_back('{owner: 1'b0, addr: 24'h0B0B0B});
        d0_q.push_back('{owner: 1'b0, tmo: 1'b1});
        tick();
        b_req0 = 1'b0;
        tick();
        tick();
        tick();
        check("tmo_grant_cycle4", {30'd0, b_gnt0, b_done0}, 32'h2);
        tick();
        check("tmo_done_and_err", {29'd0, b_done0, timeout_err0, b_gnt0}, 32'h6);
        tick();
        check("tmo_err_one_cycle", {31'd0, timeout_err0}, 32'd0);

        // Ack on the limit cycle wins over the timeout.
        b_req0 = 1'b1;
        g0_q.push_back('{owner: 1'b0, addr: 24'h0B0B0B});
        d0_q.push_back('{owner: 1'b0, tmo: 1'b0});
        tick();
        b_req0 = 1'b0;
        tick();
        tick();
        tick();
        mem_ack0 = 1'b1;
        tick();
        mem_ack0 = 1'b0;
        check("ack_on_limit", {30'd0, b_done0, timeout_err0}, 32'h2);
        tick();

        // Reset mid-GRANT: immediate reset values, no done pulse afterwards.
        a_req0 = 1'b1;
        g0_q.push_back('{owner: 1'b1, addr: 24'hA0A0A0});
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_mid_grant", {25'd0, a_gnt0, b_gnt0, a_done0, b_done0, mem_valid0, a_select0, timeout_err0}, 32'd0);
        a_req0 = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Fixed priority: A wins three ties in a row.
        do_reset();
        a_addr1 = 24'h111111;
        b_addr1 = 24'h222222;
        for (int t = 0; t < 3; t++) begin
            g1_q.push_back('{owner: 1'b1, addr: 24'h111111});
            d1_q.push_back('{owner: 1'b1, tmo: 1'b0});
        end
        a_req1 = 1'b1;
        b_req1 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            w = 0;
            while (!(a_gnt1 || b_gnt1) && w < 10) begin
                tick();
                w++;
            end
            check("fp_grant_wait", {31'd0, w < 10}, 32'd1);
            tick();
            mem_ack1 = 1'b1;
            tick();
            mem_ack1 = 1'b0;
            if (t == 2) begin
                a_req1 = 1'b0;
                b_req1 = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) tick();

        check("g0_q_drained", g0_q.size(), 32'd0);
        check("d0_q_drained", d0_q.size(), 32'd0);
        check("g1_q_drained", g1_q.size(), 32'd0);
        check("d1_q_drained", d1_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
